imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory writer for the PROCESSOR/IMEM/CPU system. It accepts a little-endian byte stream through a valid/ready handshake and assembles it into 32-bit words. It writes those words into IMEM through a word-addressed write port, holding the CPU core in reset until the image is complete. This replaces the simulation-only practice of preloading `imem.mem[]` with a synthesizable path that feeds the CPU's instruction-fetch side.

## Interface
- `ADDR_W`, 10, IMEM word-address width; depth = 2**ADDR_W words, indexed the same way as `PC[11:2]`.
- `CLK`  input  1  clock; all state changes on rising edge.
- `RST_X`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid`  input  1  byte present on `in_data`.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader can accept; a byte transfers on a rising edge with `in_valid && in_ready`.
- `we`  output  1  IMEM write strobe, one cycle per word.
- `waddr`  output  ADDR_W  IMEM word index.
- `wdata`  output  32  IMEM write data.
- `cpu_rst_x`  output  1  active-low reset for the CPU/PC; low until the image is loaded.
- `done`  output  1  image loaded; sticky until reset.
- `err`  output  1  load rejected; sticky until reset.

## Operation
- Stream format:
  - `LEN_LO`, `LEN_HI`: 16-bit word count N.
  - N×4 payload bytes, each word LSB first, written to word addresses 0..N-1 in order.
  - Trailing checksum byte, only when the checksum feature is configured.
- States:
  - `LEN0`: accept `LEN_LO` → `LEN1`.
  - `LEN1`: accept `LEN_HI`. Then:
    - N > 2**ADDR_W → `ERR`.
    - N == 0 → `CSUM` if checksum is enabled, else `DONE`.
    - Otherwise → `DATA`.
  - `DATA`:
    - 2-bit byte counter places each byte into `wdata[8*i +: 8]`.
    - On the 4th byte, issue a write, increment the word counter and clear the byte counter.
    - After word N-1, go to `CSUM` if enabled, else `DONE`.
  - `CSUM`: accept one byte; if the running sum is correct → `DONE`, else → `ERR`.
  - `DONE`: `done=1`, `cpu_rst_x=1`, `in_ready=0`; holds until reset.
  - `ERR`: `err=1`, `cpu_rst_x=0`, `in_ready=0`; holds until reset.
- `in_ready = 1` in `LEN0`, `LEN1`, `DATA` and `CSUM`; it is a registered state decode with no combinational path from `in_valid`.
- Bytes offered while `in_ready=0` are not consumed. Gaps in `in_valid` (`in_valid=0` cycles) are legal at any point and only stall the loader.
- Word counter is ADDR_W+1 bits wide, so N == 2**ADDR_W completes without wrap.
- `waddr` is the low ADDR_W bits of the word counter.
- Reset (`RST_X=0`), including mid-load:
  - state → `LEN0`; byte and word counters → 0.
  - `we`=0, `waddr`=0, `wdata`=0, `in_ready`=0, `done`=0, `err`=0.
  - `cpu_rst_x`=0 immediately (asynchronous).
  - `in_ready` rises in the first cycle after reset deasserts.
  - IMEM contents already written are left as-is.

## Timing
- Write latency: 4th byte of word k accepted at edge t → `we=1` with `waddr=k` and the full `wdata` during cycle t..t+1 (registered outputs, single cycle).
- Back-to-back words at full rate give `we` at most once every 4 cycles. `wdata` holds its last value while `we=0`.
- Release without checksum: last payload byte accepted at edge t → last `we` in cycle t+1 → `done`/`cpu_rst_x` rise at edge t+2. The final IMEM write therefore lands one edge before the CPU leaves reset.
- Release with checksum: the checksum byte cannot be accepted before edge t+1 (the last write edge). `done` rises at the edge after the checksum byte is accepted.
- N == 0: `done` rises at the edge after `LEN_HI` is accepted (after the checksum byte when enabled).
- `err` rises at the edge after the offending `LEN_HI` or checksum byte is accepted.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - 8-bit modular sum over `LEN_LO`, `LEN_HI`, all payload bytes and the trailing checksum byte must equal 0x00.
  - Mismatch → `ERR`; the CPU stays in reset.
- Not defined: no `CSUM` state, no trailing byte; `ERR` is reachable only through oversize N.

## Test plan
- No checksum, stream 02 00 13 00 00 00 93 02 00 00 → writes (0, 0x00000013) then (1, 0x00000293); `done`/`cpu_rst_x` rise two cycles after the last byte; `err`=0.
- Same stream with `in_valid` deasserted for 3 cycles between every byte → identical writes and order; no byte is lost or duplicated; `we` never high for more than one cycle.
- `ADDR_W`=10, N = 0x0401 (bytes 01 04) → `ERR` right after `LEN_HI`; `in_ready`=0; no `we`; `cpu_rst_x` stays 0. N = 0x0400 loads 1024 words with final `waddr`=1023, then `done`.
- `IMEM_LOADER_CSUM_EN`, stream 01 00 13 00 00 00 EC → write (0, 0x00000013) then `done`. Same stream with last byte ED → `err`=1 and `cpu_rst_x`=0.
- N = 0 (00 00, plus 00 when checksum is enabled) → no `we`; `done` the cycle after the last header byte.
- `RST_X` pulsed low after 6 bytes of a 2-word load → all outputs go to reset values at once; `cpu_rst_x`=0. A full reload then writes words 0 and 1 correctly and releases the CPU.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: assembles a little-endian byte stream into 32-bit words and holds the CPU in reset until the image is in.
// Optional trailing 8-bit checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              cpu_rst_x,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 32'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM,
`endif
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   logic [7:0]       len_lo;
   logic [15:0]      len;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] word_cnt;
   logic             xfer;
   logic [15:0]      len_new;
   logic             last_word;

   assign xfer      = in_valid && in_ready;
   assign len_new   = {in_data, len_lo};
   assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_new;
   assign sum_new = sum + in_data;
`endif

   // done/err/cpu_rst_x are registered decodes of the state; in_ready follows the next state
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state     <= S_LEN0;
         len_lo    <= 8'd0;
         len       <= 16'd0;
         byte_cnt  <= 2'd0;
         word_cnt  <= '0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= 32'd0;
         in_ready  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cpu_rst_x <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         sum       <= 8'd0;
`endif
      end else begin
         we        <= 1'b0;
         done      <= (state == S_DONE);
         err       <= (state == S_ERR);
         cpu_rst_x <= (state == S_DONE);
         case (state)
            S_LEN0: begin
               in_ready <= 1'b1;
               if (xfer) begin
                  len_lo <= in_data;
`ifdef IMEM_LOADER_CSUM_EN
                  sum    <= in_data;
`endif
                  state  <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (xfer) begin
                  len <= len_new;
`ifdef IMEM_LOADER_CSUM_EN
                  sum <= sum_new;
`endif
                  if (32'(len_new) > DEPTH) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                  end else if (len_new == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                     state    <= S_CSUM;
`else
                     state    <= S_DONE;
                     in_ready <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  wdata[{byte_cnt, 3'b000} +: 8] <= in_data;
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                  sum      <= sum_new;
`endif
                  if (byte_cnt == 2'd3) begin
                     we       <= 1'b1;
                     waddr    <= word_cnt[ADDR_W-1:0];
                     word_cnt <= word_cnt + 1'b1;
                     if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state    <= S_CSUM;
`else
                        state    <= S_FLUSH;
                        in_ready <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  state    <= (sum_new == 8'd0) ? S_DONE : S_ERR;
               end
            end
`endif
            // one idle cycle so the last IMEM write lands before the CPU is released
            S_FLUSH: begin
               in_ready <= 1'b0;
               state    <= S_DONE;
            end
            default: begin
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
